// File: rtl/maxheap_pkg.sv
// Types shared between the maxheap and its pop-side consumer stage.
// Also hosts the saturating helper used by the optional statistics counters.
package maxheap_pkg;

    localparam int DATA_WIDTH = 10;
    localparam int PRIO_WIDTH = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2
    } pop_state_t;

    typedef struct packed {
        logic signed [DATA_WIDTH-1:0] data;
        logic signed [PRIO_WIDTH-1:0] prio;
    } heap_entry_t;

    function automatic logic [15:0] sat_add16(input logic [15:0] a, input logic [15:0] b);
        logic [16:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        return sum[16] ? 16'hFFFF : sum[15:0];
    endfunction

endpackage

// File: rtl/maxheap_pop_fifo.sv
// Registered (non fall-through) DEPTH-entry FIFO with count and synchronous flush.
// Pointers wrap naturally (DEPTH is a power of two); count is one bit wider.
module maxheap_pop_fifo #(
    parameter int WIDTH = 42,
    parameter int DEPTH = 2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   flush,
    input  logic                   wr_en,
    input  logic [WIDTH-1:0]       wr_data,
    input  logic                   rd_en,
    output logic [WIDTH-1:0]       rd_data,
    output logic                   not_empty,
    output logic [$clog2(DEPTH):0] count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem_reg [DEPTH];
    logic [AW-1:0]    wr_ptr_reg;
    logic [AW-1:0]    rd_ptr_reg;
    logic [AW:0]      count_reg;
    logic             do_wr;
    logic             do_rd;

    assign do_rd = rd_en && (count_reg != '0);
    // A write into a full FIFO is only legal when the head leaves on the same edge.
    assign do_wr = wr_en && ((count_reg != FULL_CNT) || do_rd);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else if (flush) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (do_wr) wr_ptr_reg <= wr_ptr_reg + AW'(1);
            if (do_rd) rd_ptr_reg <= rd_ptr_reg + AW'(1);
            case ({do_wr, do_rd})
                2'b10:   count_reg <= count_reg + (AW+1)'(1);
                2'b01:   count_reg <= count_reg - (AW+1)'(1);
                default: count_reg <= count_reg;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) mem_reg[i] <= '0;
        end else if (do_wr && !flush) begin
            mem_reg[wr_ptr_reg] <= wr_data;
        end
    end

    assign rd_data   = mem_reg[rd_ptr_reg];
    assign not_empty = (count_reg != '0);
    assign count     = count_reg;

endmodule

// File: rtl/maxheap_pop_stage.sv
// Pop-side consumer of the maxheap: requests pops while buffer credit exists and streams results out.
// Optional feature macro: MAXHEAP_POP_STATS_EN adds pop_count / drop_count outputs.
module maxheap_pop_stage #(
    parameter int DATA_WIDTH = maxheap_pkg::DATA_WIDTH,
    parameter int PRIO_WIDTH = maxheap_pkg::PRIO_WIDTH,
    parameter int DEPTH      = 2
) (
    input  logic                         sink_clk,
    input  logic                         reset,
    input  logic                         heap_empty,
    output logic                         pop_req,
    input  logic                         pop_valid,
    input  logic signed [DATA_WIDTH-1:0] pop_data,
    input  logic signed [PRIO_WIDTH-1:0] pop_prio,
    input  logic                         flush,
    input  logic                         source_ready,
    output logic                         source_valid,
    output logic signed [DATA_WIDTH-1:0] source_data,
    output logic signed [PRIO_WIDTH-1:0] source_prio,
    output logic [$clog2(DEPTH):0]       occupancy
`ifdef MAXHEAP_POP_STATS_EN
    ,
    output logic [15:0]                  pop_count,
    output logic [15:0]                  drop_count
`endif
);

    import maxheap_pkg::*;

    localparam int AW = $clog2(DEPTH);
    localparam int EW = DATA_WIDTH + PRIO_WIDTH;
    localparam logic [AW:0] DEPTH_CNT = (AW+1)'(DEPTH);

    pop_state_t    state_reg;
    pop_state_t    state_next;
    logic          drop_reg;
    logic          drop_next;
    logic          in_flight;
    logic          resp_fire;
    logic          fifo_wr;
    logic          fifo_rd;
    logic [AW:0]   fifo_count;
    logic [EW-1:0] fifo_rd_data;

    // The outstanding pop holds a FIFO slot so a returning response always has room.
    assign in_flight = (state_reg != IDLE);
    assign occupancy = fifo_count + {{AW{1'b0}}, in_flight};

    assign resp_fire = (state_reg == WAIT) && pop_valid;
    assign fifo_wr   = resp_fire && !drop_reg && !flush;
    assign fifo_rd   = source_valid && source_ready;

    always_ff @(posedge sink_clk or negedge reset) begin
        if (!reset) begin
            state_reg <= IDLE;
            drop_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            drop_reg  <= drop_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        drop_next  = drop_reg;
        pop_req    = 1'b0;
        case (state_reg)
            IDLE: begin
                if (!heap_empty && (occupancy < DEPTH_CNT) && !flush) state_next = REQ;
            end
            REQ: begin
                pop_req    = 1'b1;
                state_next = WAIT;
            end
            WAIT: begin
                if (pop_valid) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
        // A flush while a pop is outstanding poisons exactly that one response.
        if (resp_fire) begin
            drop_next = 1'b0;
        end else if (flush && in_flight) begin
            drop_next = 1'b1;
        end
    end

    maxheap_pop_fifo #(
        .WIDTH (EW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (sink_clk),
        .rst_n     (reset),
        .flush     (flush),
        .wr_en     (fifo_wr),
        .wr_data   ({pop_data, pop_prio}),
        .rd_en     (fifo_rd),
        .rd_data   (fifo_rd_data),
        .not_empty (source_valid),
        .count     (fifo_count)
    );

    assign source_data = fifo_rd_data[EW-1:PRIO_WIDTH];
    assign source_prio = fifo_rd_data[PRIO_WIDTH-1:0];

`ifdef MAXHEAP_POP_STATS_EN
    logic [15:0] pop_count_reg;
    logic [15:0] drop_count_reg;
    logic [AW:0] flushed_entries;
    logic [15:0] drop_inc;

    // The head transferred on the flush edge was delivered, so it is not counted as dropped.
    assign flushed_entries = flush ? (fifo_count - {{AW{1'b0}}, fifo_rd}) : '0;
    assign drop_inc        = 16'(flushed_entries) + 16'(resp_fire && (drop_reg || flush));

    always_ff @(posedge sink_clk or negedge reset) begin
        if (!reset) begin
            pop_count_reg  <= '0;
            drop_count_reg <= '0;
        end else begin
            pop_count_reg  <= sat_add16(pop_count_reg, 16'(fifo_wr));
            drop_count_reg <= sat_add16(drop_count_reg, drop_inc);
        end
    end

    assign pop_count  = pop_count_reg;
    assign drop_count = drop_count_reg;
`endif

endmodule

// File: tb/tb_maxheap_pop_stage.sv
// Self-checking bench for maxheap_pop_stage: behavioural heap responder plus output scoreboard.
// Build with MAXHEAP_POP_STATS_EN defined to also check the statistics counters.
module tb_maxheap_pop_stage;

    localparam int DW    = 10;
    localparam int PW    = 32;
    localparam int DEPTH = 2;
    localparam int OW    = $clog2(DEPTH) + 1;

    typedef struct packed {
        logic [DW-1:0] data;
        logic [PW-1:0] prio;
    } ent_t;

    logic                 sink_clk;
    logic                 reset;
    logic                 heap_empty;
    logic                 pop_req;
    logic                 pop_valid;
    logic signed [DW-1:0] pop_data;
    logic signed [PW-1:0] pop_prio;
    logic                 flush;
    logic                 source_ready;
    logic                 source_valid;
    logic signed [DW-1:0] source_data;
    logic signed [PW-1:0] source_prio;
    logic [OW-1:0]        occupancy;
`ifdef MAXHEAP_POP_STATS_EN
    logic [15:0]          pop_count;
    logic [15:0]          drop_count;
`endif

    // responder / spurious-pulse sources
    logic          resp_valid;
    logic [DW-1:0] resp_data;
    logic [PW-1:0] resp_prio;
    logic          spur_valid;
    logic [DW-1:0] spur_data;
    logic [PW-1:0] spur_prio;
    logic          heap_block;
    int            resp_delay;

    ent_t heap_q[$];
    ent_t exp_q[$];

    int tests_run  = 0;
    int fail_cnt   = 0;
    int preq_cnt   = 0;
    int rx_cnt     = 0;
    int acc_cnt    = 0;
    int drop_resp  = 0;
    int drop_flush = 0;
    int saw40      = 0;

    assign pop_valid = resp_valid | spur_valid;
    assign pop_data  = resp_valid ? resp_data : spur_data;
    assign pop_prio  = resp_valid ? resp_prio : spur_prio;

    maxheap_pop_stage #(
        .DATA_WIDTH (DW),
        .PRIO_WIDTH (PW),
        .DEPTH      (DEPTH)
    ) dut (
        .sink_clk     (sink_clk),
        .reset        (reset),
        .heap_empty   (heap_empty),
        .pop_req      (pop_req),
        .pop_valid    (pop_valid),
        .pop_data     (pop_data),
        .pop_prio     (pop_prio),
        .flush        (flush),
        .source_ready (source_ready),
        .source_valid (source_valid),
        .source_data  (source_data),
        .source_prio  (source_prio),
        .occupancy    (occupancy)
`ifdef MAXHEAP_POP_STATS_EN
        ,
        .pop_count    (pop_count),
        .drop_count   (drop_count)
`endif
    );

    initial sink_clk = 1'b0;
    always #5 sink_clk = ~sink_clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests_run++;
        if (got !== exp) begin
            fail_cnt++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic ent_t mk(input int d, input int p);
        ent_t e;
        e.data = DW'(d);
        e.prio = PW'(p);
        return e;
    endfunction

    // Heap model: pops an element on pop_req, answers resp_delay cycles later.
    initial begin : responder
        ent_t cur;
        bit   pend;
        bit   abn;
        bit   disc;
        int   cnt;
        resp_valid = 1'b0;
        resp_data  = '0;
        resp_prio  = '0;
        heap_empty = 1'b0;
        cur  = '0;
        pend = 1'b0;
        abn  = 1'b0;
        disc = 1'b0;
        cnt  = 0;
        forever begin
            @(negedge sink_clk);
            resp_valid = 1'b0;
            if (pend) begin
                if (!reset) abn = 1'b1;
                disc = disc | flush;
                cnt--;
                if (cnt <= 0) begin
                    pend       = 1'b0;
                    resp_valid = 1'b1;
                    resp_data  = cur.data;
                    resp_prio  = cur.prio;
                    if (!abn) begin
                        if (disc) begin
                            drop_resp++;
                        end else begin
                            exp_q.push_back(cur);
                            acc_cnt++;
                        end
                    end
                end
            end else if (reset && pop_req) begin
                if (heap_q.size() == 0) begin
                    check_eq("heap_underflow", 64'(heap_q.size()), 64'd1);
                    cur = '0;
                end else begin
                    cur = heap_q.pop_front();
                end
                pend = 1'b1;
                abn  = 1'b0;
                disc = flush;
                cnt  = resp_delay - 1;
            end
            heap_empty = heap_block || (heap_q.size() == 0);
        end
    end

    // Output monitor and scoreboard.
    initial begin : monitor
        forever begin
            @(negedge sink_clk);
            if (reset) begin
                if (pop_req) preq_cnt++;
                if (source_valid && source_ready) begin
                    rx_cnt++;
                    $display("[TB] xfer %0d: data=%0d prio=%0d", rx_cnt, source_data, source_prio);
                    if (source_prio == 40) saw40++;
                    if (exp_q.size() == 0) begin
                        check_eq("sb_extra_xfer", 64'(exp_q.size()), 64'd1);
                    end else begin
                        ent_t e;
                        e = exp_q.pop_front();
                        check_eq("sb_data", 64'(source_data), 64'(e.data));
                        check_eq("sb_prio", 64'(source_prio), 64'(e.prio));
                    end
                end
                if (flush) begin
                    drop_flush += exp_q.size();
                    exp_q.delete();
                end
            end
        end
    end

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : main
        bit seen;
        int base;
        reset        = 1'b0;
        flush        = 1'b0;
        source_ready = 1'b0;
        heap_block   = 1'b0;
        spur_valid   = 1'b0;
        spur_data    = '0;
        spur_prio    = '0;
        resp_delay   = 2;
        heap_q.push_back(mk(7, 95));
        heap_q.push_back(mk(8, 80));

        // reset held with a non-empty heap
        repeat (3) begin
            @(negedge sink_clk);
            check_eq("rst_pop_req", 64'(pop_req), 64'd0);
            check_eq("rst_src_valid", 64'(source_valid), 64'd0);
            check_eq("rst_occupancy", 64'(occupancy), 64'd0);
            check_eq("rst_src_data", 64'(source_data), 64'd0);
            check_eq("rst_src_prio", 64'(source_prio), 64'd0);
        end
        @(posedge sink_clk); #1;
        reset        = 1'b1;
        source_ready = 1'b1;

        // basic pop: response two cycles after pop_req
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(posedge sink_clk); #1;
            seen = pop_valid;
        end
        check_eq("t2_pop_valid_seen", 64'(seen), 64'd1);
        @(negedge sink_clk);
        check_eq("t2_src_valid", 64'(source_valid), 64'd1);
        check_eq("t2_src_prio", 64'(source_prio), 64'd95);
        check_eq("t2_src_data", 64'(source_data), 64'd7);
        seen = 1'b0;
        for (int i = 0; i < 4 && !seen; i++) begin
            @(negedge sink_clk);
            seen = pop_req;
        end
        check_eq("t2_next_req", 64'(seen), 64'd1);
        repeat (10) @(negedge sink_clk);
        check_eq("t2_rx_cnt", 64'(rx_cnt), 64'd2);

        // backpressure: only DEPTH pops issued while stalled
        @(posedge sink_clk); #1;
        source_ready = 1'b0;
        base = preq_cnt;
        heap_q.push_back(mk(1, 90));
        heap_q.push_back(mk(2, 70));
        heap_q.push_back(mk(3, 50));
        repeat (20) @(negedge sink_clk);
        check_eq("t3_req_cnt_stall", 64'(preq_cnt - base), 64'd2);
        check_eq("t3_occupancy", 64'(occupancy), 64'd2);
        check_eq("t3_src_valid", 64'(source_valid), 64'd1);
        check_eq("t3_src_prio", 64'(source_prio), 64'd90);
        check_eq("t3_src_data", 64'(source_data), 64'd1);
        repeat (3) @(negedge sink_clk);
        check_eq("t3_src_prio_hold", 64'(source_prio), 64'd90);
        @(posedge sink_clk); #1;
        source_ready = 1'b1;
        repeat (20) @(negedge sink_clk);
        check_eq("t3_req_cnt_after", 64'(preq_cnt - base), 64'd3);
        check_eq("t3_rx_cnt", 64'(rx_cnt), 64'd5);

        // flush while waiting for a response
        resp_delay = 4;
        base = preq_cnt;
        heap_q.push_back(mk(4, 40));
        heap_q.push_back(mk(5, 30));
        seen = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            @(negedge sink_clk);
            seen = pop_req;
        end
        check_eq("t4_req_seen", 64'(seen), 64'd1);
        @(posedge sink_clk); #1;
        flush = 1'b1;
        @(posedge sink_clk); #1;
        flush = 1'b0;
        @(negedge sink_clk);
        check_eq("t4_src_valid_flush", 64'(source_valid), 64'd0);
        check_eq("t4_occ_in_flight", 64'(occupancy), 64'd1);
        repeat (20) @(negedge sink_clk);
        check_eq("t4_prio40_seen", 64'(saw40), 64'd0);
        check_eq("t4_req_cnt", 64'(preq_cnt - base), 64'd2);
        check_eq("t4_rx_cnt", 64'(rx_cnt), 64'd6);

        // empty heap, spurious pop_valid in IDLE
        @(posedge sink_clk); #1;
        heap_block = 1'b1;
        resp_delay = 2;
        heap_q.push_back(mk(6, 20));
        base = preq_cnt;
        repeat (8) @(negedge sink_clk);
        check_eq("t5_no_req", 64'(preq_cnt - base), 64'd0);
        @(posedge sink_clk); #1;
        spur_valid = 1'b1;
        spur_data  = DW'(3);
        spur_prio  = PW'(99);
        @(posedge sink_clk); #1;
        spur_valid = 1'b0;
        repeat (3) @(negedge sink_clk);
        check_eq("t5_spur_valid", 64'(source_valid), 64'd0);
        check_eq("t5_spur_occ", 64'(occupancy), 64'd0);
        @(posedge sink_clk); #1;
        heap_block = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 3 && !seen; i++) begin
            @(negedge sink_clk);
            seen = pop_req;
        end
        check_eq("t5_req_resume", 64'(seen), 64'd1);
        repeat (10) @(negedge sink_clk);
        check_eq("t5_rx_cnt", 64'(rx_cnt), 64'd7);

`ifdef MAXHEAP_POP_STATS_EN
        check_eq("t6_pop_count", 64'(pop_count), 64'(acc_cnt));
        check_eq("t6_drop_count", 64'(drop_count), 64'(drop_resp + drop_flush));
`endif

        // reset during WAIT; the late response must be ignored
        resp_delay = 6;
        heap_q.push_back(mk(9, 10));
        seen = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            @(negedge sink_clk);
            seen = pop_req;
        end
        check_eq("t7_req_seen", 64'(seen), 64'd1);
        @(posedge sink_clk); #1;
        heap_block = 1'b1;
        reset      = 1'b0;
        @(negedge sink_clk);
        check_eq("t7_rst_pop_req", 64'(pop_req), 64'd0);
        check_eq("t7_rst_occ", 64'(occupancy), 64'd0);
        check_eq("t7_rst_src_valid", 64'(source_valid), 64'd0);
`ifdef MAXHEAP_POP_STATS_EN
        check_eq("t7_rst_pop_count", 64'(pop_count), 64'd0);
        check_eq("t7_rst_drop_count", 64'(drop_count), 64'd0);
`endif
        @(posedge sink_clk); #1;
        reset = 1'b1;
        base  = preq_cnt;
        repeat (10) @(negedge sink_clk);
        check_eq("t7_late_occ", 64'(occupancy), 64'd0);
        check_eq("t7_late_src_valid", 64'(source_valid), 64'd0);
        check_eq("t7_late_rx_cnt", 64'(rx_cnt), 64'd7);
        check_eq("t7_late_no_req", 64'(preq_cnt - base), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, fail_cnt);
        $finish;
    end

endmodule
